// File: rtl/product_out_port_pkg.sv
// Shared types and constants for the product output port.
// Imported by the port top, its FIFO and the bench.
package product_out_port_pkg;

  localparam logic [15:0] BASE_ADDR_DEF = 16'h0140;

  localparam int ST_FULL  = 0;
  localparam int ST_PHASE = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } phase_e;

endpackage

// File: rtl/product_out_port_if.sv
// I/O bus strobes/address plus the outgoing word stream.
// The tri-state data byte stays a plain inout on the top.
interface product_out_port_if;

  logic [15:0] addr;
  logic        ior_;
  logic        iow_;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output addr,
    output ior_,
    output iow_,
    output out_ready,
    input  out_word,
    input  out_valid
  );

  modport slave (
    input  addr,
    input  ior_,
    input  iow_,
    input  out_ready,
    output out_word,
    output out_valid
  );

endinterface

// File: rtl/product_out_port_word_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define what is live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/product_out_port.sv
// Pairs high/low byte writes into 16-bit words, queues them,
// and exposes full/phase/overflow status on BASE_ADDR+1.
module product_out_port
  import product_out_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset,
  product_out_port_if.slave  bus,
  inout  wire  [7:0]         data
);

  phase_e     state;
  phase_e     state_nx;
  logic       iow_q;
  logic       ior_q;
  logic [7:0] hold_hi;
  logic       ovf;
  logic       hit_data;
  logic       hit_stat;
  logic       wr_ev;
  logic       rd_ev;
  logic       load_hi;
  logic       push;
  logic       pop;
  logic       drop;
  logic       full;
  logic       empty;
  logic [7:0] status;

  assign hit_data = bus.addr == BASE_ADDR;
  assign hit_stat = bus.addr == BASE_ADDR + 16'd1;
  assign wr_ev    = !bus.iow_ && iow_q && hit_data;
  assign rd_ev    = !bus.ior_ && ior_q && hit_stat;

  always_ff @(posedge clock) begin
    if (reset) begin
      iow_q <= 1'b1;
      ior_q <= 1'b1;
    end else begin
      iow_q <= bus.iow_;
      ior_q <= bus.ior_;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= HI;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (wr_ev) state_nx = (state == HI) ? LO : HI;
  end

  always_comb begin
    load_hi = 1'b0;
    push    = 1'b0;
    unique case (state)
      HI: load_hi = wr_ev;
      LO: push    = wr_ev;
    endcase
  end

  assign pop  = bus.out_valid && bus.out_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clock) begin
    if (reset)        hold_hi <= '0;
    else if (load_hi) hold_hi <= data;
  end

  // A drop on the same edge as a status read keeps ovf set.
  always_ff @(posedge clock) begin
    if (reset)      ovf <= 1'b0;
    else if (drop)  ovf <= 1'b1;
    else if (rd_ev) ovf <= 1'b0;
  end

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_PHASE] = state == LO;
    status[ST_OVF]   = ovf;
  end

  assign data = (!bus.ior_ && hit_stat) ? status : 8'bz;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({hold_hi, data}),
    .dout  (bus.out_word),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;

endmodule

// File: tb/tb_product_out_port.sv
// Bench for product_out_port: vector table plus scoreboard
// of expected words checked whenever the consumer accepts one.
module tb_product_out_port;
  import product_out_port_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] DPORT = 16'h0140;
  localparam logic [15:0] SPORT = 16'h0141;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          hold;
    logic [7:0]  mid_st;
    logic [15:0] word;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  wire  [7:0]  data;
  logic [7:0]  tb_data;
  logic        tb_drv;
  logic        rand_en;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];
  vec_t        tv [4];

  product_out_port_if bus();

  assign data = tb_drv ? tb_data : 8'bz;

  // Undriven bus floats high; status never reads 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  product_out_port #(
    .BASE_ADDR (DPORT),
    .DEPTH     (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .data  (data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v,
                    input int hold);
    bus.addr = a;
    tb_data  = v;
    tb_drv   = 1'b1;
    bus.iow_ = 1'b0;
    repeat (hold) cyc();
    bus.iow_ = 1'b1;
    tb_drv   = 1'b0;
    cyc();
  endtask

  task automatic rd(output logic [7:0] v);
    bus.addr = SPORT;
    bus.ior_ = 1'b0;
    @(negedge clock);
    v = data;
    cyc();
    bus.ior_ = 1'b1;
    cyc();
  endtask

  task automatic chk_st(input string name, input logic [7:0] exp);
    logic [7:0] v;
    rd(v);
    chk(name, 32'(v), 32'(exp));
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 64) begin
      cyc();
      n++;
    end
    bus.out_ready = 1'b0;
    chk("drain_done", 32'(bus.out_valid), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_extra: got %h, expected none",
                 bus.out_word);
      end else begin
        chk("sb_word", 32'(bus.out_word), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    tv[0] = '{8'h12, 8'h34, 1, 8'h02, 16'h1234};
    tv[1] = '{8'hAB, 8'hCD, 3, 8'h02, 16'hABCD};
    tv[2] = '{8'h00, 8'hFF, 1, 8'h02, 16'h00FF};
    tv[3] = '{8'hFF, 8'h00, 2, 8'h02, 16'hFF00};

    reset         = 1'b1;
    rand_en       = 1'b0;
    tb_drv        = 1'b0;
    tb_data       = '0;
    bus.addr      = '0;
    bus.ior_      = 1'b1;
    bus.iow_      = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) cyc();
    @(negedge clock);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_word", 32'(bus.out_word), 32'd0);
    chk("rst_data_z", 32'(data), 32'hFF);
    reset = 1'b0;
    cyc();
    chk_st("st_reset", 8'h00);

    wr(16'h0142, 8'h55, 1);
    wr(SPORT, 8'h66, 1);
    chk_st("st_other_addr", 8'h00);
    chk("other_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      wr(DPORT, tv[i].hi, tv[i].hold);
      chk_st("st_mid", tv[i].mid_st);
      bus.addr = DPORT;
      tb_data  = tv[i].lo;
      tb_drv   = 1'b1;
      bus.iow_ = 1'b0;
      exp_q.push_back(tv[i].word);
      @(negedge clock);
      chk("valid_pre", 32'(bus.out_valid), 32'd0);
      chk("data_z_wr", 32'(data), 32'(tv[i].lo));
      cyc();
      @(negedge clock);
      chk("valid_post", 32'(bus.out_valid), 32'd1);
      chk("word_head", 32'(bus.out_word), 32'(tv[i].word));
      repeat (tv[i].hold - 1) cyc();
      bus.iow_ = 1'b1;
      tb_drv   = 1'b0;
      cyc();
      chk_st("st_after", 8'h00);
      drain();
    end

    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(i);
      wr(DPORT, 8'hA0 + b, 1);
      if (i < DEPTH) exp_q.push_back({8'hA0 + b, b});
      wr(DPORT, b, 1);
    end
    chk_st("st_ovf", 8'h05);
    chk_st("st_ovf_clr", 8'h01);
    drain();
    chk_st("st_ovf_empty", 8'h00);

    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(i);
      wr(DPORT, 8'hC0 + b, 1);
      exp_q.push_back({8'hC0 + b, b});
      wr(DPORT, b, 1);
    end
    wr(DPORT, 8'hEE, 1);
    bus.addr      = DPORT;
    tb_data       = 8'h99;
    tb_drv        = 1'b1;
    bus.iow_      = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.push_back(16'hEE99);
    cyc();
    bus.out_ready = 1'b0;
    bus.iow_      = 1'b1;
    tb_drv        = 1'b0;
    cyc();
    chk_st("st_full_pop", 8'h01);
    drain();

    rand_en = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      int n;
      b = 8'(i);
      wr(DPORT, 8'h00, 1);
      n = 0;
      while (exp_q.size() >= DEPTH && n < 100) begin
        cyc();
        n++;
      end
      chk("wrap_space", 32'(exp_q.size() < DEPTH), 32'd1);
      exp_q.push_back({8'h00, b});
      wr(DPORT, b, 1);
    end
    rand_en = 1'b0;
    drain();
    chk_st("st_wrap", 8'h00);

    wr(DPORT, 8'h77, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_data_z", 32'(data), 32'hFF);
    chk_st("st_rst_pair", 8'h00);
    wr(DPORT, 8'h11, 1);
    @(negedge clock);
    chk("rst2_half", 32'(bus.out_valid), 32'd0);
    bus.addr = DPORT;
    tb_data  = 8'h22;
    tb_drv   = 1'b1;
    bus.iow_ = 1'b0;
    exp_q.push_back(16'h1122);
    cyc();
    @(negedge clock);
    chk("rst2_data_wr", 32'(data), 32'h22);
    chk("rst2_valid1", 32'(bus.out_valid), 32'd1);
    chk("rst2_word", 32'(bus.out_word), 32'h1122);
    bus.iow_ = 1'b1;
    tb_drv   = 1'b0;
    cyc();
    drain();

    bus.addr = SPORT;
    bus.ior_ = 1'b0;
    reset    = 1'b1;
    cyc();
    @(negedge clock);
    chk("rst_rd_data", 32'(data), 32'h00);
    bus.ior_ = 1'b1;
    #1;
    chk("rst_rd_rel", 32'(data), 32'hFF);
    reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/product_out_port.md
# product_out_port

Output interface at I/O port 0x0140 on the 8-bit I/O bus. Consumes the byte pairs the bus master writes there (product high byte, then low byte) and reassembles them into 16-bit words. Buffers the words in a small FIFO and hands them to a downstream consumer over a valid/ready handshake. Also exposes a readable status register at BASE_ADDR+1.

## Interface
- BASE_ADDR, 16'h0140: data port address (write-only); status port is BASE_ADDR+1 (read-only).
- DEPTH, 4: FIFO depth in 16-bit words; power of two, ≥2.

- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset; one clock, synchronous active-high (fixed).
- addr  in  16  I/O bus address.
- data  inout  8  I/O bus data; driven only during a status read, otherwise Z.
- ior_  in  1  read strobe, active low.
- iow_  in  1  write strobe, active low.
- out_word  out  16  head-of-FIFO word {high, low}.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_word when out_valid && out_ready at posedge.

## Operation
- Strobes are sampled every posedge into iow_q/ior_q.
- A write event is iow_ sampled 0, iow_q 1 and addr==BASE_ADDR. Strobe low for multiple cycles gives one event. Writes to other addresses are ignored.
- Pairing FSM has two states:
  - HI (reset): on a write event, hold_hi <= data; go to LO.
  - LO: on a write event, form {hold_hi, data}. If the FIFO is not full, or a pop occurs in the same cycle, push it; otherwise drop the word and set ovf. Return to HI.
- Status byte: bit0 = full, bit1 = FSM in LO, bit2 = ovf (sticky), bits7:3 = 0.
- data = status whenever ior_==0 && addr==BASE_ADDR+1 (combinational); else Z. Reads of BASE_ADDR are not driven.
- A read event is ior_ sampled 0, ior_q 1 and addr==BASE_ADDR+1. It clears ovf at that posedge, so the value already driven shows ovf=1. If a drop happens on the same edge, ovf ends 1 (set wins).
- FIFO: registered pointers plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - Pop when out_valid && out_ready.
  - Push and pop together on a full FIFO are both performed, count unchanged.
  - Pop on empty is a no-op.
- Reset values: FSM=HI, hold_hi=0, FIFO empty, out_valid=0, out_word=0 when empty, ovf=0, iow_q=ior_q=1, data=Z.
- Reset asserted mid-pair discards the half word. Reset mid-read releases data as soon as ior_ rises.

## Timing
- Low-byte write event at edge k: word is in the FIFO after edge k; out_valid=1 from k (visible in cycle k+1) if the FIFO was empty.
- out_word is combinational from the head entry; it changes the cycle after a pop.
- Status reflects state registered at the previous edge. full, bit1 and ovf update one cycle after the causing event.
- Back-to-back write events need iow_ high for ≥1 sampled cycle between them (master holds each level ≥1 clock).

## Structure
- Shared package holds BASE_ADDR default, status bit indices (ST_FULL=0, ST_PHASE=1, ST_OVF=2), and the FSM state encoding (HI/LO).
- One sub-module, word_fifo: parameterised synchronous FIFO with push, pop, din, dout, full, empty and the simultaneous-full rule above.
- The top keeps the strobe sampling, pairing FSM, status logic and tri-state driver.

## Test plan
- Basic pair: after reset, write 0x12 then 0x34 to 0x0140 with out_ready=0. Expect out_word=0x1234 and out_valid=1 one cycle after the second event; status read at 0x0141 = 0x00.
- Long strobe: hold iow_ low 3 cycles writing 0xAB, then 0xCD. Expect exactly one word 0xABCD; status mid-pair reads 0x02.
- Overflow: out_ready=0, write DEPTH+1 pairs. Expect status 0x05 and the first DEPTH words intact in order. Then read status: 0x05 driven, next read 0x01.
- Full with pop: FIFO full and out_ready=1 on the same edge as a low-byte event. Expect no drop, count stays DEPTH, ovf stays 0.
- Wrap: push/pop 3×DEPTH words 0x0000..0x000B with random out_ready. Expect the output sequence matches in order with no loss.
- Reset mid-pair: write 0x77, assert reset 1 cycle, write 0x11, 0x22. Expect a single word 0x1122, out_valid=0 during/after reset until then, data=Z throughout writes.
